dice_display_mux: RTL and testbench
===================================

Name: dice_display_mux

Overview:
- Consumer end of the dice game result interface: takes Win, Lose, Roll, DiceOut1 and DiceOut2 from the game FSM.
- Drives the board's 8-digit multiplexed, active-low seven-segment display.
- Shows both dice, their sum, and a 4-letter status message.
- One-hot digit scanning is driven from a clock prescaler; inputs are snapshotted once per frame so a frame never tears.

Parameters:
- SCAN_DIV, 100000: CLK cycles per digit slot; legal range ≥ 2.
- BLINK_FRAMES, 64: frames per blink half-period; used only with DICE_BLINK_EN.

Ports:
- CLK  in  1  system clock; all flops on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- Win  in  1  game won.
- Lose  in  1  game lost.
- Roll  in  1  game awaiting a roll.
- DiceOut1  in  3  die 1 value; 1..6 valid.
- DiceOut2  in  3  die 2 value; 1..6 valid.
- Anode  out  8  digit enables, active-low; bit 0 is the rightmost digit.
- Cathode  out  7  segments {g,f,e,d,c,b,a}, active-low.

Behaviour:
- Reset (async assert, synchronous release):
  - Anode=8'hFF, Cathode=7'h7F.
  - Prescaler=0, digit index=7, snapshot all zero, blink counters 0.
- Prescaler:
  - Counts 0..SCAN_DIV-1, then wraps.
  - The wrap cycle is a "tick".
- On each tick:
  - Digit index advances 7→0→1→…→7.
  - Anode and Cathode register new values on the same edge; there are no other output changes.
  - Exactly one Anode bit is low after the first tick.
- Frame start (tick where index goes 7→0):
  - Capture Win, Lose, Roll, DiceOut1, DiceOut2 into the snapshot.
  - Digit 0 in the same edge uses the captured values via bypass.
  - All other digits use the snapshot.
- First frame start occurs SCAN_DIV cycles after reset release.
- Digit map:
  - d0 = DiceOut2.
  - d1 = DiceOut1.
  - d2 = sum ones.
  - d3 = sum tens.
  - d7..d4 = message, left to right.
- Die digit:
  - Value 1..6 shows the numeral.
  - Value 0 shows blank.
  - Value 7 shows dash.
- Sum:
  - 4-bit unsigned DiceOut1+DiceOut2, computed only when both dice are 1..6, giving range 2..12.
  - Tens digit shows "1" for sums ≥10, else blank (no leading zero).
  - If either die is invalid, both sum digits are blank.
- Message, priority Win > Lose > Roll > none:
  - "PASS" when Win.
  - "FAIL" when Lose.
  - "roLL" when Roll.
  - Blank otherwise.
  - Win and Lose both high shows PASS.
- Segment codes (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - P=0001100, A=0001000, S=0010010, F=0001110, I=1111001, L=1000111, r=0101111, o=0100011.
  - blank=1111111, dash=0111111.
- Input changes mid-frame have no visible effect until the next frame start.
- Reset asserted mid-frame: outputs return immediately to reset values, and the scan restarts as after power-up.

Optional Feature:
- Macro DICE_BLINK_EN.
- Defined:
  - A frame counter runs while the snapshot shows Win or Lose.
  - Message digits d7..d4 alternate visible and blank every BLINK_FRAMES frames, starting visible.
  - The counter and phase clear to visible whenever the snapshot shows neither Win nor Lose, and on reset.
  - Dice and sum digits never blink.
- Undefined: message is steady, no blink logic is present, and BLINK_FRAMES is ignored.

Test Plan:
- Reset, SCAN_DIV=4:
  - Anode=FF and Cathode=7F held for 4 cycles after release.
  - Then Anode=FE, with Anode stepping FD,FB,…,7F every 4 cycles and wrapping to FE.
- Dice 3,4 with Win=1:
  - d0=0110000, d1=0011001, d2=1111000, d3=blank.
  - d7..d4 = P,A,S,S.
- Dice 6,6 with Lose=1:
  - d2=0100100, d3=1111001.
  - Message F,A,I,L.
- Dice 2,2 with Roll=1:
  - Sum digits 4 and blank; message r,o,L,L.
  - Change DiceOut1 to 5 during d3: no change until the next frame, where d1=0010010.
- Win=Lose=1 shows PASS.
- Dice 0,3 with all flags 0: d1 blank, sum digits blank, message blank.
- Dice 7,3: d1 shows dash.
- Reset mid-frame at index 4: Anode=FF immediately, restart as in the first scenario.
- With DICE_BLINK_EN, BLINK_FRAMES=2 and Win held:
  - Message visible 2 frames, blank 2 frames, repeating.
  - Dropping Win clears the blink at the next frame.

Source files
------------

// File: rtl/dice_display_mux.sv
// dice_display_mux: scans the dice game result onto an 8-digit, active-low,
// multiplexed seven-segment display.
//   d0 = DiceOut2, d1 = DiceOut1, d3:d2 = sum of both dice,
//   d7..d4 = status message (PASS / FAIL / roLL / blank).
// Inputs are captured once per frame, on the tick where the digit index wraps
// from 7 to 0, so a frame never mixes old and new values.
// Optional macro DICE_BLINK_EN: when defined, the message blinks every
// BLINK_FRAMES frames while the captured result shows Win or Lose.
module dice_display_mux #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic       CLK,
    input  logic       reset_n,
    input  logic       Win,
    input  logic       Lose,
    input  logic       Roll,
    input  logic [2:0] DiceOut1,
    input  logic [2:0] DiceOut2,
    output logic [7:0] Anode,
    output logic [6:0] Cathode
);

    localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_S     = 7'b0010010;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_I     = 7'b1111001;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_O     = 7'b0100011;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    // Decimal numeral; anything above 9 is left blank
    function automatic logic [6:0] num_seg(input logic [3:0] n);
        logic [6:0] s;
        s = SEG_BLANK;
        case (n)
            4'd0: s = SEG_0;
            4'd1: s = SEG_1;
            4'd2: s = SEG_2;
            4'd3: s = SEG_3;
            4'd4: s = SEG_4;
            4'd5: s = SEG_5;
            4'd6: s = SEG_6;
            4'd7: s = SEG_7;
            4'd8: s = SEG_8;
            4'd9: s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Die face: 1..6 numeral, 0 blank (no die yet), 7 dash (illegal value)
    function automatic logic [6:0] die_seg(input logic [2:0] v);
        logic [6:0] s;
        s = SEG_BLANK;
        case (v)
            3'd0:    s = SEG_BLANK;
            3'd7:    s = SEG_DASH;
            default: s = num_seg(4'(v));
        endcase
        return s;
    endfunction

    logic [CNT_W-1:0] prescale;
    logic [2:0]       idx;
    logic             tick;
    logic             frame_start;

    logic             snap_win;
    logic             snap_lose;
    logic             snap_roll;
    logic [2:0]       snap_d1;
    logic [2:0]       snap_d2;

    logic             msg_hide;

    // Combinational next-display signals
    logic [2:0]       next_idx;
    logic             eff_win;
    logic             eff_lose;
    logic             eff_roll;
    logic [2:0]       eff_d1;
    logic [2:0]       eff_d2;
    logic             both_valid;
    logic [3:0]       sum;
    logic [3:0]       sum_ones;
    logic [6:0]       ones_seg;
    logic [6:0]       tens_seg;
    logic [6:0]       msg7;
    logic [6:0]       msg6;
    logic [6:0]       msg5;
    logic [6:0]       msg4;
    logic [6:0]       digit_seg;
    logic [7:0]       anode_next;

    assign tick        = (prescale == CNT_MAX);
    assign frame_start = tick && (idx == 3'd7);

    // Scan prescaler: one tick every SCAN_DIV clocks
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            prescale <= '0;
        end else if (tick) begin
            prescale <= '0;
        end else begin
            prescale <= prescale + CNT_W'(1);
        end
    end

    // Digit index; starts at 7 so the first tick opens a new frame on digit 0
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            idx <= 3'd7;
        end else if (tick) begin
            idx <= next_idx;
        end
    end

    // Per-frame snapshot of the game result
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            snap_win  <= 1'b0;
            snap_lose <= 1'b0;
            snap_roll <= 1'b0;
            snap_d1   <= 3'd0;
            snap_d2   <= 3'd0;
        end else if (frame_start) begin
            snap_win  <= Win;
            snap_lose <= Lose;
            snap_roll <= Roll;
            snap_d1   <= DiceOut1;
            snap_d2   <= DiceOut2;
        end
    end

`ifdef DICE_BLINK_EN
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_off;

    // Blink phase advances per frame only while Win/Lose persists across frames;
    // a fresh Win/Lose (or any other result) restarts in the visible phase
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (frame_start) begin
            if ((Win || Lose) && (snap_win || snap_lose)) begin
                if (blink_cnt == BLINK_LAST) begin
                    blink_cnt <= '0;
                    blink_off <= ~blink_off;
                end else begin
                    blink_cnt <= blink_cnt + BLINK_W'(1);
                end
            end else begin
                blink_cnt <= '0;
                blink_off <= 1'b0;
            end
        end
    end

    assign msg_hide = blink_off;
`else
    assign msg_hide = 1'b0;
`endif

    // Segment pattern for the digit that becomes active on the next tick
    always_comb begin
        next_idx = idx + 3'd1;

        // On the frame-start edge digit 0 sees the values being captured
        eff_win  = snap_win;
        eff_lose = snap_lose;
        eff_roll = snap_roll;
        eff_d1   = snap_d1;
        eff_d2   = snap_d2;
        if (frame_start) begin
            eff_win  = Win;
            eff_lose = Lose;
            eff_roll = Roll;
            eff_d1   = DiceOut1;
            eff_d2   = DiceOut2;
        end

        both_valid = (eff_d1 != 3'd0) && (eff_d1 != 3'd7) &&
                     (eff_d2 != 3'd0) && (eff_d2 != 3'd7);
        sum      = 4'd0;
        sum_ones = 4'd0;
        ones_seg = SEG_BLANK;
        tens_seg = SEG_BLANK;
        if (both_valid) begin
            sum      = 4'(eff_d1) + 4'(eff_d2);
            sum_ones = (sum >= 4'd10) ? (sum - 4'd10) : sum;
            ones_seg = num_seg(sum_ones);
            tens_seg = (sum >= 4'd10) ? SEG_1 : SEG_BLANK;
        end

        msg7 = SEG_BLANK;
        msg6 = SEG_BLANK;
        msg5 = SEG_BLANK;
        msg4 = SEG_BLANK;
        if (eff_win) begin
            msg7 = SEG_P;
            msg6 = SEG_A;
            msg5 = SEG_S;
            msg4 = SEG_S;
        end else if (eff_lose) begin
            msg7 = SEG_F;
            msg6 = SEG_A;
            msg5 = SEG_I;
            msg4 = SEG_L;
        end else if (eff_roll) begin
            msg7 = SEG_R;
            msg6 = SEG_O;
            msg5 = SEG_L;
            msg4 = SEG_L;
        end
        if (msg_hide) begin
            msg7 = SEG_BLANK;
            msg6 = SEG_BLANK;
            msg5 = SEG_BLANK;
            msg4 = SEG_BLANK;
        end

        digit_seg = SEG_BLANK;
        case (next_idx)
            3'd0: digit_seg = die_seg(eff_d2);
            3'd1: digit_seg = die_seg(eff_d1);
            3'd2: digit_seg = ones_seg;
            3'd3: digit_seg = tens_seg;
            3'd4: digit_seg = msg4;
            3'd5: digit_seg = msg5;
            3'd6: digit_seg = msg6;
            3'd7: digit_seg = msg7;
            default: digit_seg = SEG_BLANK;
        endcase

        anode_next = ~(8'b0000_0001 << next_idx);
    end

    // Registered display drive, updated only on scan ticks
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            Anode   <= 8'hFF;
            Cathode <= 7'h7F;
        end else if (tick) begin
            Anode   <= anode_next;
            Cathode <= digit_seg;
        end
    end

endmodule

// File: tb/tb_dice_display_mux.sv
// Self-checking bench for dice_display_mux with a short scan period.
// Expected digit patterns come from a hand-written vector table; each applied
// frame pushes its eight {Anode, Cathode} expectations onto a scoreboard queue
// that is popped as every scan slot appears.
module tb_dice_display_mux;

    localparam int unsigned SCAN_DIV     = 4;
    localparam int unsigned BLINK_FRAMES = 2;

`ifdef DICE_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    // Independent copy of the segment alphabet, gfedcba active-low
    localparam logic [6:0] C0 = 7'b1000000;
    localparam logic [6:0] C1 = 7'b1111001;
    localparam logic [6:0] C2 = 7'b0100100;
    localparam logic [6:0] C3 = 7'b0110000;
    localparam logic [6:0] C4 = 7'b0011001;
    localparam logic [6:0] C5 = 7'b0010010;
    localparam logic [6:0] C6 = 7'b0000010;
    localparam logic [6:0] C7 = 7'b1111000;
    localparam logic [6:0] CP = 7'b0001100;
    localparam logic [6:0] CA = 7'b0001000;
    localparam logic [6:0] CS = 7'b0010010;
    localparam logic [6:0] CF = 7'b0001110;
    localparam logic [6:0] CI = 7'b1111001;
    localparam logic [6:0] CL = 7'b1000111;
    localparam logic [6:0] CR = 7'b0101111;
    localparam logic [6:0] CO = 7'b0100011;
    localparam logic [6:0] BL = 7'b1111111;
    localparam logic [6:0] DA = 7'b0111111;

    logic       CLK;
    logic       reset_n;
    logic       Win;
    logic       Lose;
    logic       Roll;
    logic [2:0] DiceOut1;
    logic [2:0] DiceOut2;
    logic [7:0] Anode;
    logic [6:0] Cathode;

    dice_display_mux #(
        .SCAN_DIV    (SCAN_DIV),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .CLK     (CLK),
        .reset_n (reset_n),
        .Win     (Win),
        .Lose    (Lose),
        .Roll    (Roll),
        .DiceOut1(DiceOut1),
        .DiceOut2(DiceOut2),
        .Anode   (Anode),
        .Cathode (Cathode)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic             win;
        logic             lose;
        logic             roll;
        logic [2:0]       d1;
        logic [2:0]       d2;
        logic [7:0][6:0]  seg;   // seg[k] = expected Cathode on digit k
    } vec_t;

    typedef struct packed {
        logic [7:0] an;
        logic [6:0] ca;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pending_wait = SCAN_DIV;

    function automatic vec_t mk(input logic w, input logic l, input logic r,
                                input logic [2:0] a, input logic [2:0] b,
                                input logic [6:0] s0, input logic [6:0] s1,
                                input logic [6:0] s2, input logic [6:0] s3,
                                input logic [6:0] s4, input logic [6:0] s5,
                                input logic [6:0] s6, input logic [6:0] s7);
        vec_t v;
        v.win  = w;
        v.lose = l;
        v.roll = r;
        v.d1   = a;
        v.d2   = b;
        v.seg  = {s7, s6, s5, s4, s3, s2, s1, s0};
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] an_exp, input logic [6:0] ca_exp);
        checks++;
        if (Anode !== an_exp || Cathode !== ca_exp) begin
            errors++;
            $display("FAIL %s: got Anode=%h Cathode=%b, want Anode=%h Cathode=%b",
                     name, Anode, Cathode, an_exp, ca_exp);
        end
    endtask

    task automatic push_frame(input logic [7:0][6:0] seg);
        exp_t e;
        logic [7:0] a;
        for (int k = 0; k < 8; k++) begin
            a = 8'b0000_0001 << k;
            e.an = ~a;
            e.ca = seg[k];
            sb_q.push_back(e);
        end
    endtask

    // Wait for the next scan slot and compare it with the head of the scoreboard
    task automatic check_slot(input string tag, input int k);
        exp_t e;
        repeat (pending_wait) @(posedge CLK);
        pending_wait = SCAN_DIV;
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s slot %0d: scoreboard empty", tag, k);
        end else begin
            e = sb_q.pop_front();
            check($sformatf("%s d%0d", tag, k), e.an, e.ca);
        end
    endtask

    // Apply one frame's inputs before its frame-start edge, then check its slots
    task automatic run_frame(input string tag, input vec_t v, input int stop_after,
                             input int chg_slot, input logic [2:0] chg_val);
        Win      = v.win;
        Lose     = v.lose;
        Roll     = v.roll;
        DiceOut1 = v.d1;
        DiceOut2 = v.d2;
        push_frame(v.seg);
        for (int k = 0; k < 8; k++) begin
            check_slot(tag, k);
            if (k == chg_slot) DiceOut1 = chg_val;
            if (k == stop_after) break;
        end
    endtask

    // Hold reset, release on a falling edge, confirm outputs idle until the first tick
    task automatic reset_seq(input string tag);
        reset_n = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check({tag, " in_reset"}, 8'hFF, 7'h7F);
        @(negedge CLK);
        reset_n = 1'b1;
        for (int i = 0; i < int'(SCAN_DIV) - 1; i++) begin
            @(posedge CLK);
            #1;
            check($sformatf("%s hold%0d", tag, i), 8'hFF, 7'h7F);
        end
        pending_wait = 1;
    endtask

    vec_t vecs[7];
    vec_t v_win;
    vec_t v_none;
    vec_t v_roll;
    logic [6:0] m7;
    logic [6:0] m6;
    logic [6:0] m5;
    logic [6:0] m4;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //              W     L     R     D1    D2    d0  d1  d2  d3  d4  d5  d6  d7
        vecs[0] = mk(1'b1, 1'b0, 1'b0, 3'd4, 3'd3, C3, C4, C7, BL, CS, CS, CA, CP);
        vecs[1] = mk(1'b0, 1'b1, 1'b0, 3'd6, 3'd6, C6, C6, C2, C1, CL, CI, CA, CF);
        vecs[2] = mk(1'b0, 1'b0, 1'b1, 3'd2, 3'd2, C2, C2, C4, BL, CL, CL, CO, CR);
        vecs[3] = mk(1'b0, 1'b0, 1'b1, 3'd5, 3'd2, C2, C5, C7, BL, CL, CL, CO, CR);
        vecs[4] = mk(1'b1, 1'b1, 1'b0, 3'd1, 3'd1, C1, C1, C2, BL, CS, CS, CA, CP);
        vecs[5] = mk(1'b0, 1'b0, 1'b0, 3'd0, 3'd3, C3, BL, BL, BL, BL, BL, BL, BL);
        vecs[6] = mk(1'b0, 1'b0, 1'b0, 3'd7, 3'd3, C3, DA, BL, BL, BL, BL, BL, BL);

        Win      = 1'b0;
        Lose     = 1'b0;
        Roll     = 1'b0;
        DiceOut1 = 3'd0;
        DiceOut2 = 3'd0;
        reset_n  = 1'b0;

        reset_seq("por");

        for (int i = 0; i < 7; i++) begin
            // Vector 2 changes DiceOut1 while d3 is lit; vector 3 shows it a frame later
            if (i == 2) run_frame($sformatf("vec%0d", i), vecs[i], 7, 3, 3'd5);
            else        run_frame($sformatf("vec%0d", i), vecs[i], 7, -1, 3'd0);
        end

        // Sum of exactly ten: tens digit appears, ones shows zero
        run_frame("sum10", mk(1'b0, 1'b0, 1'b1, 3'd5, 3'd5, C5, C5, C0, C1, CL, CL, CO, CR),
                  7, -1, 3'd0);

        // Asynchronous reset part-way through a frame (while digit 4 is lit)
        run_frame("midrst", vecs[0], 4, -1, 3'd0);
        @(posedge CLK);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst async", 8'hFF, 7'h7F);
        sb_q.delete();
        reset_seq("rst2");
        run_frame("after_rst", vecs[0], 7, -1, 3'd0);

        // Message blink while Win is held; steady when the blink option is absent
        v_none = mk(1'b0, 1'b0, 1'b0, 3'd2, 3'd1, C1, C2, C3, BL, BL, BL, BL, BL);
        v_roll = mk(1'b0, 1'b0, 1'b1, 3'd2, 3'd1, C1, C2, C3, BL, CL, CL, CO, CR);
        run_frame("blk_none", v_none, 7, -1, 3'd0);
        for (int f = 0; f < 10; f++) begin
            // Phase pattern vis,vis,blank,blank,vis,vis,blank then Roll, then vis,vis
            if (f == 7) begin
                run_frame("blk_drop", v_roll, 7, -1, 3'd0);
            end else begin
                if (BLINK_ON && (f == 2 || f == 3 || f == 6)) begin
                    m7 = BL; m6 = BL; m5 = BL; m4 = BL;
                end else begin
                    m7 = CP; m6 = CA; m5 = CS; m4 = CS;
                end
                v_win = mk(1'b1, 1'b0, 1'b0, 3'd2, 3'd1, C1, C2, C3, BL, m4, m5, m6, m7);
                run_frame($sformatf("blk_win%0d", f), v_win, 7, -1, 3'd0);
            end
        end

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard leftover: got %0d entries, want 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
